fgyrus_pcm_fetch: RTL

FGYRUS_PCM_FETCH -- requirements
Module: fgyrus_pcm_fetch

---
 rtl/fgyrus_pcm_pkg.sv | 25 ++
 rtl/fgyrus_pcm_fifo.sv | 55 +++++
 rtl/fgyrus_pcm_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fgyrus_pcm_pkg.sv
// Shared types and default constants for the fgyrus PCM fetch block.
package fgyrus_pcm_pkg;

  localparam int unsigned PCM_MEM_DATA_W_DEF = 32;
  localparam int unsigned PCM_MEM_ADDR_W_DEF = 8;
  localparam int unsigned NUM_SAMPLES_DEF    = 128;
  localparam int unsigned RD_LAT_DEF         = 2;
  localparam int unsigned FIFO_DEPTH_DEF     = 4;

  // Tag index field is sized for the widest supported buffer; users slice it.
  localparam int unsigned TAG_IDX_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } pcm_state_e;

  typedef struct packed {
    logic                 chan;
    logic [TAG_IDX_W-1:0] idx;
    logic                 last;
  } pcm_tag_t;

endpackage

// File: rtl/fgyrus_pcm_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module fgyrus_pcm_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Storage array; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
      else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/fgyrus_pcm_fetch.sv
// Fetches one PCM frame (L then R channel) from the acortex buffer and
// streams it downstream with valid/ready flow control.
module fgyrus_pcm_fetch
  import fgyrus_pcm_pkg::*;
#(
  parameter int unsigned PCM_MEM_DATA_W = PCM_MEM_DATA_W_DEF,
  parameter int unsigned PCM_MEM_ADDR_W = PCM_MEM_ADDR_W_DEF,
  parameter int unsigned NUM_SAMPLES    = NUM_SAMPLES_DEF,
  parameter int unsigned RD_LAT         = RD_LAT_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      acortex2fgyrus_pcm_rdy,
  output logic [PCM_MEM_ADDR_W-1:0] fgyrus2acortex_addr,
  input  logic [PCM_MEM_DATA_W-1:0] acortex2fgyrus_pcm_data,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic [PCM_MEM_DATA_W-1:0] sample_data,
  output logic                      sample_chan,
  output logic [PCM_MEM_ADDR_W-2:0] sample_idx,
  output logic                      sample_last,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                overrun_cnt
);

  localparam int unsigned IDX_W = PCM_MEM_ADDR_W - 1;
  localparam int unsigned TAG_W = $bits(pcm_tag_t);
  localparam int unsigned ENT_W = PCM_MEM_DATA_W + TAG_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PCM_MEM_ADDR_W-1:0] LAST_ADDR = PCM_MEM_ADDR_W'(2 * NUM_SAMPLES - 1);

  pcm_state_e                state_q, state_d;
  logic                      rdy_q, rdy_rise;
  logic [PCM_MEM_ADDR_W-1:0] cnt_q, cnt_d;
  logic [PCM_MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]                overrun_q, overrun_d;
  logic [RD_LAT-1:0]         sr_vld_q;
  pcm_tag_t                  sr_tag_q [RD_LAT];

  logic                      issue, room, accept;
  pcm_tag_t                  issue_tag, head_tag;
  logic [PCM_MEM_DATA_W-1:0] head_data;
  int unsigned               inflight;

  logic                      fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [ENT_W-1:0]          fifo_wdata, fifo_rdata;
  logic                      unused_idx_hi;

  assign rdy_rise = acortex2fgyrus_pcm_rdy && !rdy_q;

  assign issue_tag.chan = cnt_q[PCM_MEM_ADDR_W-1];
  assign issue_tag.idx  = TAG_IDX_W'(cnt_q[IDX_W-1:0]);
  assign issue_tag.last = (cnt_q == LAST_ADDR);

  // Count reads still travelling through the memory pipeline.
  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight += {31'b0, sr_vld_q[i]};
  end

  // Buffered plus in-flight entries bound the issue rate so the FIFO can
  // always absorb every returning word, regardless of backpressure.
  assign room = !fifo_full && ((32'(fifo_count) + inflight) < FIFO_DEPTH);

  // Frame FSM: next state, read issue and completion pulse.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    issue      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rdy_rise) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (room) begin
          issue  = 1'b1;
          addr_d = cnt_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && head_tag.last) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of frame-ready edges that arrive while busy.
  always_comb begin
    overrun_d = overrun_q;
    if (rdy_rise && (state_q != IDLE) && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= acortex2fgyrus_pcm_rdy;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
    end
  end

  // Read-issue shift register; the last stage lines up with returning data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) sr_tag_q[i] <= '0;
    end else begin
      sr_vld_q[0] <= issue;
      sr_tag_q[0] <= issue_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_tag_q[i] <= sr_tag_q[i-1];
      end
    end
  end

  assign fifo_wdata = {acortex2fgyrus_pcm_data, sr_tag_q[RD_LAT-1]};

  fgyrus_pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (sr_vld_q[RD_LAT-1]),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (sample_ready),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign {head_data, head_tag} = fifo_rdata;
  assign unused_idx_hi         = ^head_tag.idx;

  assign sample_valid = !fifo_empty;
  assign accept       = sample_valid && sample_ready;
  assign sample_data  = sample_valid ? head_data : '0;
  assign sample_chan  = sample_valid && head_tag.chan;
  assign sample_idx   = sample_valid ? head_tag.idx[IDX_W-1:0] : '0;
  assign sample_last  = sample_valid && head_tag.last;

  // The issued address is presented in its issue cycle and held afterwards.
  assign fgyrus2acortex_addr = issue ? cnt_q : addr_q;
  assign busy                = (state_q != IDLE);
  assign overrun_cnt         = overrun_q;

endmodule
